mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port main memory between three requesters: CPU instruction fetch, CPU data access (already decoded to the memory range), and a DMA master (PPU/SD block transfer). It sits between the CPU-side address decoder and the memory block and grants one transaction at a time using round-robin priority. A per-transaction watchdog completes transactions the memory never acknowledges and records the fault.

## Interface
- TIMEOUT, default 16'd1024: GRANT cycles without mem.data_ready before forced completion; valid range 2..65535.
- All memory_bus signals are address 16 bit, data_in/data_out 16 bit, enable/write_enable/data_ready 1 bit.

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_data  memory_bus.slave  -  requester 0 (CPU data)
- req_inst  memory_bus.slave  -  requester 1 (CPU instruction)
- req_dma  memory_bus.slave  -  requester 2 (DMA)
- mem  memory_bus.master  -  shared memory port
- grant  out  3  one-hot current owner (bit0 data, bit1 inst, bit2 dma), 0 when idle
- bus_error  out  1  sticky; set on watchdog expiry, cleared only by reset
- error_source  out  2  index of requester that timed out first; valid while bus_error=1

## Operation
- Handshake per requester: raise enable with address/data_in/write_enable stable; hold until data_ready is seen high for one cycle; drop enable (or present a new request) the following cycle.
- States: IDLE, GRANT.
- IDLE: mem.enable=0, mem.write_enable=0. If any req enable=1, pick winner by round-robin and register grant; go to GRANT.
- Round-robin: register last (2 bit). Search order last+1, last+2, last (mod 3). last resets to 2, so first tie goes data, inst, dma. last updates to winner on entry to GRANT.
- GRANT: mem.address, data_in, write_enable, enable forwarded combinationally from owner; owner data_out/data_ready driven from mem; non-owners see data_ready=0, data_out=0.
- GRANT exit on: mem.data_ready=1 (normal), owner enable dropped (abort; mem.enable falls same cycle, no data_ready to owner), or watchdog expiry. All exits go to IDLE; grant clears.
- Watchdog: 16-bit counter cleared on GRANT entry, increments each GRANT cycle. When count reaches TIMEOUT-1 without mem.data_ready, owner receives data_ready=1 with data_out=16'h0000 that cycle, mem.enable held 0 that cycle, bus_error set; error_source loaded only if bus_error was 0.
- mem.data_ready in IDLE is ignored.

## Timing
- Reset values: grant=0, bus_error=0, error_source=0, mem.enable=0, mem.write_enable=0, all req data_ready=0, state IDLE, last=2, counter=0.
- Arbitration latency: request seen in IDLE cycle N -> mem.enable=1 in cycle N+1.
- Completion: mem.data_ready in cycle M reaches owner in cycle M (combinational); IDLE at M+1; next grant at M+2 earliest. Minimum 2 cycles between memory transactions plus memory latency.
- Simultaneous events: mem.data_ready and watchdog expiry in same cycle -> normal completion, no error. Abort and data_ready in same cycle -> treated as completion.
- Reset asserted mid-GRANT: mem.enable and grant drop asynchronously; transaction discarded.
- A requester holding enable continuously gets at most one grant before each other pending requester is served.

## Test plan
- Single inst read, addr 16'h0040, memory ready after 3 cycles, data 16'hBEEF -> grant=3'b010 one cycle after request, req_inst sees data_ready with 16'hBEEF, grant back to 0 next cycle.
- All three request at once from reset, memory ready 1 cycle after enable -> grant sequence 001, 010, 100; each owner gets exactly one data_ready.
- Data requester streams continuously, DMA requests once -> grants alternate 001, 100, 001; DMA waits at most one transaction.
- TIMEOUT=8, memory never ready, DMA request -> after 8 GRANT cycles DMA sees data_ready with 16'h0000, bus_error=1, error_source=2; later inst timeout leaves error_source=2.
- Inst granted, inst drops enable before ready -> mem.enable=0 that cycle, no data_ready to inst, IDLE next cycle, no error.
- Reset pulse during data write grant -> mem.enable, mem.write_enable, grant 0 before next clock edge; after release, pending inst request granted first tie-break order data, inst, dma.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port main memory between CPU data,
// CPU instruction fetch and DMA, with a per-transaction watchdog.
module mem_port_arbiter #(
   parameter logic [15:0] TIMEOUT = 16'd1024,
   localparam int unsigned AW = 16,
   localparam int unsigned DW = 16,
   localparam int unsigned NREQ = 3,
   localparam int unsigned IW = 2
) (
   input  logic          clock,
   input  logic          reset,
   // requester 0: CPU data
   input  logic [AW-1:0] req_data_address,
   input  logic [DW-1:0] req_data_data_in,
   output logic [DW-1:0] req_data_data_out,
   input  logic          req_data_enable,
   input  logic          req_data_write_enable,
   output logic          req_data_data_ready,
   // requester 1: CPU instruction
   input  logic [AW-1:0] req_inst_address,
   input  logic [DW-1:0] req_inst_data_in,
   output logic [DW-1:0] req_inst_data_out,
   input  logic          req_inst_enable,
   input  logic          req_inst_write_enable,
   output logic          req_inst_data_ready,
   // requester 2: DMA
   input  logic [AW-1:0] req_dma_address,
   input  logic [DW-1:0] req_dma_data_in,
   output logic [DW-1:0] req_dma_data_out,
   input  logic          req_dma_enable,
   input  logic          req_dma_write_enable,
   output logic          req_dma_data_ready,
   // shared memory port
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data_in,
   input  logic [DW-1:0] mem_data_out,
   output logic          mem_enable,
   output logic          mem_write_enable,
   input  logic          mem_data_ready,
   // status
   output logic [NREQ-1:0] grant,
   output logic            bus_error,
   output logic [IW-1:0]   error_source
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   last;
   logic [IW-1:0]   cand1, cand2, winner_c;
   logic [15:0]     wd_count;
   logic [NREQ-1:0] req_en;
   logic [AW-1:0]   own_addr_c;
   logic [DW-1:0]   own_din_c;
   logic            own_en_c, own_we_c;
   logic            expire_c, done_c, ready_c;
   logic [DW-1:0]   dout_c;

   function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] i);
      return (i == IW'(2)) ? IW'(0) : IW'(i + IW'(1));
   endfunction

   assign req_en = {req_dma_enable, req_inst_enable, req_data_enable};

   // Search order last+1, last+2, last; "last" doubles as the current owner.
   always_comb begin
      cand1    = rr_next(last);
      cand2    = rr_next(cand1);
      winner_c = last;
      if (req_en[cand1])      winner_c = cand1;
      else if (req_en[cand2]) winner_c = cand2;
   end

   always_comb begin
      own_addr_c = req_dma_address;
      own_din_c  = req_dma_data_in;
      own_en_c   = req_dma_enable;
      own_we_c   = req_dma_write_enable;
      case (last)
         IW'(0): begin
            own_addr_c = req_data_address;
            own_din_c  = req_data_data_in;
            own_en_c   = req_data_enable;
            own_we_c   = req_data_write_enable;
         end
         IW'(1): begin
            own_addr_c = req_inst_address;
            own_din_c  = req_inst_data_in;
            own_en_c   = req_inst_enable;
            own_we_c   = req_inst_write_enable;
         end
         default: ;
      endcase
   end

   // A real memory acknowledge always wins over expiry or abort.
   assign expire_c = (state == S_GRANT) && own_en_c && !mem_data_ready &&
                     (wd_count == TIMEOUT - 16'd1);
   assign done_c   = (state == S_GRANT) && (mem_data_ready || !own_en_c || expire_c);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (|req_en) state_nxt = S_GRANT;
         S_GRANT: if (done_c)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last         <= IW'(2);
         wd_count     <= '0;
         grant        <= '0;
         bus_error    <= 1'b0;
         error_source <= '0;
      end else begin
         if (state == S_IDLE && |req_en) begin
            last     <= winner_c;
            grant    <= NREQ'(3'b001 << winner_c);
            wd_count <= '0;
         end else if (state == S_GRANT) begin
            wd_count <= wd_count + 16'd1;
            if (done_c) grant <= '0;
         end
         if (expire_c) begin
            bus_error <= 1'b1;
            if (!bus_error) error_source <= last;
         end
      end
   end

   always_comb begin
      mem_address         = '0;
      mem_data_in         = '0;
      mem_enable          = 1'b0;
      mem_write_enable    = 1'b0;
      req_data_data_ready = 1'b0;
      req_data_data_out   = '0;
      req_inst_data_ready = 1'b0;
      req_inst_data_out   = '0;
      req_dma_data_ready  = 1'b0;
      req_dma_data_out    = '0;
      ready_c             = mem_data_ready || expire_c;
      dout_c              = mem_data_ready ? mem_data_out : '0;
      if (state == S_GRANT) begin
         mem_address      = own_addr_c;
         mem_data_in      = own_din_c;
         mem_enable       = own_en_c && !expire_c;
         mem_write_enable = own_we_c && !expire_c;
         case (last)
            IW'(0): begin
               req_data_data_ready = ready_c;
               req_data_data_out   = dout_c;
            end
            IW'(1): begin
               req_inst_data_ready = ready_c;
               req_inst_data_out   = dout_c;
            end
            default: begin
               req_dma_data_ready = ready_c;
               req_dma_data_out   = dout_c;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester agents with a scoreboard, a latency
// configurable memory model, a vector table and hand-written corner sequences.
module tb_mem_port_arbiter;

   localparam logic [15:0] TO = 16'd8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [2:0]  en = '0, we = '0;
   logic [15:0] addr [3];
   logic [15:0] din  [3];
   wire         rdy0, rdy1, rdy2;
   wire  [15:0] dout0, dout1, dout2;
   wire  [15:0] mem_address, mem_data_in;
   logic [15:0] mem_data_out = 16'hDEAD;
   wire         mem_enable, mem_write_enable;
   logic        mem_data_ready = 1'b0;
   wire  [2:0]  grant;
   wire         bus_error;
   wire  [1:0]  error_source;

   mem_port_arbiter #(.TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .req_data_address(addr[0]), .req_data_data_in(din[0]), .req_data_data_out(dout0),
      .req_data_enable(en[0]), .req_data_write_enable(we[0]), .req_data_data_ready(rdy0),
      .req_inst_address(addr[1]), .req_inst_data_in(din[1]), .req_inst_data_out(dout1),
      .req_inst_enable(en[1]), .req_inst_write_enable(we[1]), .req_inst_data_ready(rdy1),
      .req_dma_address(addr[2]), .req_dma_data_in(din[2]), .req_dma_data_out(dout2),
      .req_dma_enable(en[2]), .req_dma_write_enable(we[2]), .req_dma_data_ready(rdy2),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
      .mem_data_ready(mem_data_ready),
      .grant(grant), .bus_error(bus_error), .error_source(error_source)
   );

   typedef struct { int r; logic [15:0] a; logic [15:0] d; logic w; } txn_t;
   typedef struct { int r; logic [15:0] exp; } sbe_t;
   typedef struct { logic [2:0] mask; int lat; int ng; logic [8:0] gseq; } vec_t;

   txn_t        pend[$];
   sbe_t        sb[$];
   logic [2:0]  glog[$];
   logic [2:0]  prev_grant = '0;
   logic [2:0]  act = '0;
   bit          agent_on = 0;
   logic [2:0]  nxt_en = '0, nxt_we = '0;
   logic [15:0] nxt_a [3];
   logic [15:0] nxt_d [3];
   logic [2:0]  h_en = '0, h_we = '0;
   logic [15:0] h_addr [3];
   logic [15:0] h_din  [3];
   int          mem_lat = 1;
   bit          mem_never = 0;
   int          mcnt = 0;
   logic        nxt_mrdy = 1'b0;
   logic [15:0] nxt_mdata = 16'hDEAD;
   logic [15:0] wr_addr = '0, wr_data = '0;
   int          n_cmp = 0, n_fail = 0;
   vec_t        vecs [6];

   function automatic logic [15:0] rd_fn(input logic [15:0] a);
      return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h1234);
   endfunction

   function automatic logic rdy_of(input int r);
      return (r == 0) ? rdy0 : (r == 1) ? rdy1 : rdy2;
   endfunction

   function automatic logic [15:0] dout_of(input int r);
      return (r == 0) ? dout0 : (r == 1) ? dout1 : dout2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic sb_pop(input int r, input logic [15:0] got);
      int idx = -1;
      for (int i = 0; i < sb.size(); i++)
         if (sb[i].r == r) begin idx = i; break; end
      if (idx < 0) chk("sb_unexpected", 32'd1, 32'd0);
      else begin
         chk("sb_data", 32'(got), 32'(sb[idx].exp));
         sb.delete(idx);
      end
   endtask

   // Negedge phase: observe DUT, update memory model and agents.
   task automatic sample();
      if (reset) begin
         mcnt = 0; nxt_mrdy = 1'b0; nxt_mdata = 16'hDEAD;
      end else if (mem_data_ready || !mem_enable) begin
         if (mem_data_ready && mem_enable && mem_write_enable) begin
            wr_addr = mem_address; wr_data = mem_data_in;
         end
         mcnt = 0; nxt_mrdy = 1'b0; nxt_mdata = 16'hDEAD;
      end else begin
         mcnt++;
         nxt_mrdy  = !mem_never && (mcnt == mem_lat);
         nxt_mdata = nxt_mrdy ? rd_fn(mem_address) : 16'hDEAD;
      end
      if (grant != 3'b000 && prev_grant == 3'b000) glog.push_back(grant);
      prev_grant = grant;
      for (int r = 0; r < 3; r++) begin
         if (rdy_of(r)) chk("ready_owner", 32'(grant[r]), 32'd1);
         if (agent_on) begin
            if (rdy_of(r)) begin
               if (act[r]) begin sb_pop(r, dout_of(r)); act[r] = 1'b0; end
               else chk("ready_unexpected", 32'd1, 32'd0);
            end
            if (!act[r]) begin
               for (int i = 0; i < pend.size(); i++) begin
                  if (pend[i].r == r) begin
                     sbe_t e;
                     nxt_a[r] = pend[i].a; nxt_d[r] = pend[i].d; nxt_we[r] = pend[i].w;
                     e.r = r; e.exp = rd_fn(pend[i].a);
                     sb.push_back(e);
                     act[r] = 1'b1;
                     pend.delete(i);
                     break;
                  end
               end
            end
            nxt_en[r] = act[r];
         end
      end
   endtask

   // One clock: drive inputs 2 time units after the rising edge, sample at the falling edge.
   task automatic cyc();
      @(posedge clock); #2;
      mem_data_ready = nxt_mrdy;
      mem_data_out   = nxt_mdata;
      for (int r = 0; r < 3; r++) begin
         if (agent_on) begin
            en[r] = nxt_en[r]; we[r] = nxt_we[r]; addr[r] = nxt_a[r]; din[r] = nxt_d[r];
         end else begin
            en[r] = h_en[r]; we[r] = h_we[r]; addr[r] = h_addr[r]; din[r] = h_din[r];
         end
      end
      @(negedge clock);
      sample();
   endtask

   task automatic do_reset();
      agent_on = 0; h_en = '0; h_we = '0;
      reset = 1'b1;
      cyc(); cyc();
      pend.delete(); sb.delete(); glog.delete();
      act = '0; nxt_en = '0; prev_grant = '0; mem_never = 0;
      reset = 1'b0;
   endtask

   task automatic wait_rdy(input int r, input int budget, output int k);
      k = 0;
      while (!rdy_of(r) && k < budget) begin cyc(); k++; end
      if (!rdy_of(r)) chk("wait_rdy_budget", 32'd0, 32'd1);
   endtask

   task automatic run_txns(input int budget);
      int c = 0;
      while (!(pend.size() == 0 && sb.size() == 0 && act == 3'b000) && c < budget) begin
         cyc(); c++;
      end
      if (c >= budget) chk("drain_budget", 32'(sb.size() + pend.size()), 32'd0);
      cyc(); cyc();
   endtask

   initial begin
      int k;
      logic [15:0] base_a [3];
      base_a[0] = 16'h0200; base_a[1] = 16'h0040; base_a[2] = 16'h0300;
      for (int r = 0; r < 3; r++) begin
         addr[r] = '0; din[r] = '0; nxt_a[r] = '0; nxt_d[r] = '0;
         h_addr[r] = '0; h_din[r] = '0;
      end

      // reset state with every requester asking and writing
      h_en = 3'b111; h_we = 3'b111;
      cyc(); cyc();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_bus_error", 32'(bus_error), 32'd0);
      chk("rst_error_source", 32'(error_source), 32'd0);
      chk("rst_mem_enable", 32'(mem_enable), 32'd0);
      chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
      chk("rst_ready", 32'({rdy2, rdy1, rdy0}), 32'd0);

      // single instruction read, memory ready 3 cycles after enable
      do_reset();
      mem_lat = 3; h_en = 3'b010; h_addr[1] = 16'h0040;
      cyc();
      chk("a_grant_c0", 32'(grant), 32'd0);
      cyc();
      chk("a_grant_c1", 32'(grant), 32'b010);
      chk("a_mem_enable", 32'(mem_enable), 32'd1);
      chk("a_mem_address", 32'(mem_address), 32'h0040);
      wait_rdy(1, 20, k);
      chk("a_latency", 32'(k), 32'd3);
      chk("a_data", 32'(dout1), 32'hBEEF);
      h_en = 3'b000;
      cyc();
      chk("a_grant_after", 32'(grant), 32'd0);

      // vector table: all start from reset, data always writes
      vecs[0] = '{mask: 3'b010, lat: 3, ng: 1, gseq: {3'b000, 3'b000, 3'b010}};
      vecs[1] = '{mask: 3'b111, lat: 1, ng: 3, gseq: {3'b100, 3'b010, 3'b001}};
      vecs[2] = '{mask: 3'b101, lat: 2, ng: 2, gseq: {3'b000, 3'b100, 3'b001}};
      vecs[3] = '{mask: 3'b110, lat: 1, ng: 2, gseq: {3'b000, 3'b100, 3'b010}};
      vecs[4] = '{mask: 3'b011, lat: 4, ng: 2, gseq: {3'b000, 3'b010, 3'b001}};
      vecs[5] = '{mask: 3'b100, lat: 5, ng: 1, gseq: {3'b000, 3'b000, 3'b100}};
      for (int v = 0; v < 6; v++) begin
         logic [8:0] gs;
         do_reset();
         mem_lat = vecs[v].lat;
         agent_on = 1;
         for (int r = 0; r < 3; r++) begin
            if (vecs[v].mask[r]) begin
               txn_t t;
               t.r = r; t.a = base_a[r] + 16'(v); t.d = 16'hC0DE + 16'(v); t.w = (r == 0);
               pend.push_back(t);
            end
         end
         run_txns(100);
         chk("vec_grant_count", 32'(glog.size()), 32'(vecs[v].ng));
         gs = vecs[v].gseq;
         for (int g = 0; g < vecs[v].ng && g < glog.size(); g++)
            chk("vec_grant_seq", 32'(glog[g]), 32'(gs[3*g +: 3]));
         if (vecs[v].mask[0]) begin
            chk("vec_wr_addr", 32'(wr_addr), 32'(16'h0200 + 16'(v)));
            chk("vec_wr_data", 32'(wr_data), 32'(16'hC0DE + 16'(v)));
         end
         chk("vec_bus_error", 32'(bus_error), 32'd0);
      end

      // data streams, DMA asks once: DMA must be next after the first data grant
      do_reset();
      mem_lat = 2; agent_on = 1;
      for (int i = 0; i < 4; i++) begin
         txn_t t;
         t.r = 0; t.a = 16'h0400 + 16'(i); t.d = '0; t.w = 1'b0;
         pend.push_back(t);
      end
      begin
         txn_t t;
         t.r = 2; t.a = 16'h0500; t.d = '0; t.w = 1'b0;
         pend.push_back(t);
      end
      run_txns(200);
      chk("stream_count", 32'(glog.size()), 32'd5);
      if (glog.size() == 5) begin
         chk("stream_g0", 32'(glog[0]), 32'b001);
         chk("stream_g1", 32'(glog[1]), 32'b100);
         chk("stream_g2", 32'(glog[2]), 32'b001);
         chk("stream_g4", 32'(glog[4]), 32'b001);
      end

      // memory ready exactly on the watchdog cycle: normal completion
      do_reset();
      mem_lat = 7; h_en = 3'b100; h_addr[2] = 16'h0300;
      cyc(); cyc();
      wait_rdy(2, 20, k);
      chk("b_cycles", 32'(k), 32'd7);
      chk("b_data", 32'(dout2), 32'(rd_fn(16'h0300)));
      chk("b_mem_enable", 32'(mem_enable), 32'd1);
      h_en = 3'b000;
      cyc();
      chk("b_bus_error", 32'(bus_error), 32'd0);

      // memory never ready: DMA times out, then inst times out
      mem_never = 1; h_en = 3'b100;
      cyc(); cyc();
      chk("c_grant", 32'(grant), 32'b100);
      wait_rdy(2, 20, k);
      chk("c_cycles", 32'(k), 32'd7);
      chk("c_data_zero", 32'(dout2), 32'd0);
      chk("c_mem_enable_held", 32'(mem_enable), 32'd0);
      chk("c_bus_error_pre", 32'(bus_error), 32'd0);
      h_en = 3'b000;
      cyc();
      chk("c_bus_error", 32'(bus_error), 32'd1);
      chk("c_error_source", 32'(error_source), 32'd2);
      chk("c_grant_idle", 32'(grant), 32'd0);
      h_en = 3'b010; h_addr[1] = 16'h0040;
      cyc(); cyc();
      wait_rdy(1, 20, k);
      chk("c2_cycles", 32'(k), 32'd7);
      chk("c2_data_zero", 32'(dout1), 32'd0);
      h_en = 3'b000;
      cyc();
      chk("c2_error_source", 32'(error_source), 32'd2);
      chk("c2_bus_error", 32'(bus_error), 32'd1);

      // inst abort before ready
      do_reset();
      mem_never = 1; h_en = 3'b010;
      cyc(); cyc();
      chk("d_grant", 32'(grant), 32'b010);
      cyc();
      h_en = 3'b000;
      cyc();
      chk("d_mem_enable", 32'(mem_enable), 32'd0);
      chk("d_no_ready", 32'(rdy1), 32'd0);
      cyc();
      chk("d_grant_idle", 32'(grant), 32'd0);
      chk("d_bus_error", 32'(bus_error), 32'd0);

      // abort together with ready counts as completion
      mem_never = 0; mem_lat = 2; h_en = 3'b010;
      cyc(); cyc(); cyc();
      h_en = 3'b000;
      cyc();
      chk("d2_ready", 32'(rdy1), 32'd1);
      chk("d2_data", 32'(dout1), 32'hBEEF);
      cyc();
      chk("d2_grant_idle", 32'(grant), 32'd0);

      // reset pulse during a data write grant
      do_reset();
      mem_never = 1; h_en = 3'b001; h_we = 3'b001; h_addr[0] = 16'h0200; h_din[0] = 16'hC0DE;
      cyc(); cyc();
      chk("e_grant", 32'(grant), 32'b001);
      chk("e_mem_we", 32'(mem_write_enable), 32'd1);
      chk("e_mem_din", 32'(mem_data_in), 32'hC0DE);
      h_en = 3'b011;
      cyc();
      #1 reset = 1'b1;
      #1;
      chk("e_async_mem_enable", 32'(mem_enable), 32'd0);
      chk("e_async_mem_we", 32'(mem_write_enable), 32'd0);
      chk("e_async_grant", 32'(grant), 32'd0);
      h_en = 3'b010; h_we = 3'b000;
      cyc();
      reset = 1'b0;
      cyc();
      chk("e_inst_first", 32'(grant), 32'b010);
      h_en = 3'b000;
      cyc(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
